uart_rx_frame: RTL and testbench
================================

// Module: uart_rx_frame
// PURPOSE
//  Packet controller behind uart_rx. Consumes its byte strobes, hunts a sync byte and parses frames [SYNC][LEN][PAYLOAD x LEN][CSUM].
//  Holds the payload in a small buffer for the consumer (ready/valid), with byte readout by address.
//  Flags UART, length, checksum, timeout and overrun errors. Sits between uart_rx and the command decoder.
// PARAMETERS
//  CLK_HZ       100_000_000  system clock frequency
//  BAUD         115200       line rate; BIT_CYC = CLK_HZ/BAUD (integer division) = 868
//  MAX_LEN      16           max payload bytes; power of two, 2..64
//  SYNC_BYTE    8'hA5        frame start marker
//  TIMEOUT_BITS 20           inter-byte timeout in bit times; TO_CYC = BIT_CYC*TIMEOUT_BITS = 17360
// PORTS
//  clk        in   1              system clock
//  rst        in   1              synchronous, active-high reset
//  rx_ready   in   1              1-cycle strobe from uart_rx: rx_val holds a good byte
//  rx_error   in   1              1-cycle strobe from uart_rx: parity/stop-bit failure
//  rx_val     in   8              received byte; sampled only when rx_ready=1
//  pkt_valid  out  1              payload buffer holds a complete, checked frame
//  pkt_ready  in   1              consumer accepts the frame
//  pkt_len    out  clog2(MAX_LEN+1)  payload length; stable while pkt_valid=1
//  rd_addr    in   clog2(MAX_LEN)    payload byte index
//  rd_data    out  8              buffer[rd_addr], registered, 1-cycle latency
//  pkt_err    out  1              1-cycle pulse: frame aborted or byte dropped
//  err_code   out  3              0 UART, 1 LEN, 2 CSUM, 3 TIMEOUT, 4 OVERRUN; held until next pkt_err
//  err_count  out  8              total pkt_err pulses, saturates at 255
// BEHAVIOUR
//  Reset: state=IDLE. pkt_valid, pkt_err, pkt_len, err_code, err_count, rd_data, timeout counter all 0. Buffer contents undefined.
//  FSM states:
//   IDLE: rx_ready && rx_val==SYNC_BYTE -> LEN. Other bytes and rx_error are ignored silently.
//   LEN: byte in 1..MAX_LEN -> store len, csum_acc=byte, idx=0, -> PAYLOAD. Otherwise -> pkt_err code 1, -> IDLE.
//   PAYLOAD: write buf[idx]=byte, csum_acc^=byte, idx++. After the LEN-th byte -> CSUM.
//   CSUM: byte==csum_acc -> HOLD and assert pkt_valid next cycle. Otherwise -> pkt_err code 2, -> IDLE.
//   HOLD: pkt_valid=1. pkt_valid && pkt_ready -> pkt_valid=0 next cycle, -> IDLE.
//  Checksum: 8-bit XOR of LEN and all payload bytes. SYNC is excluded.
//  Timeout: counter clears on every rx_ready and counts in LEN/PAYLOAD/CSUM only.
//   Reaching TO_CYC -> pkt_err code 3, -> IDLE. The counter is held at 0 in IDLE and HOLD.
//  Error in frame: rx_error in LEN/PAYLOAD/CSUM -> pkt_err code 0, -> IDLE.
//   rx_error and rx_ready in the same cycle: error wins and the byte is discarded.
//  Overrun: rx_ready in HOLD, including the handshake cycle -> byte dropped, pkt_err code 4.
//   State and buffer are unchanged.
//  pkt_err rises the cycle after the causing event. err_code and err_count update in that same cycle.
//  Abort never touches pkt_valid. No buffer writes happen in HOLD, so the buffer is stable while pkt_valid=1.
//  rd_data reads the buffer in any state. Addresses >= pkt_len return stale data.
//  Throughput: one byte per rx_ready. No internal latency beyond one cycle per transition.
//  Reset mid-frame: immediately IDLE, partial frame discarded, err_count cleared.
// STRUCTURE
//  uart_defs.vh (shared with uart_rx/uart_tx): state encodings, ERR_* codes, BIT_CYC macro.
//  Sub-module uart_frame_buf: MAX_LEN x 8 simple dual-port RAM with synchronous write and registered read (maps to iCE40 EBR).
//  Top level holds the FSM, idx, csum_acc, timeout counter and error counter.
// TESTING (uart_rx instance driven at 8680 ns/bit, 100 MHz clock, even parity, or direct strobes)
//  A5 03 11 22 33 03 -> pkt_valid=1, pkt_len=3, rd_addr 0/1/2 -> 11/22/33. pkt_ready -> pkt_valid=0 next cycle.
//  95 95 A5 02 AA 55 FD -> leading 95s ignored with no pkt_err. pkt_len=2, data AA 55.
//  A5 03 11 22 33 04 -> pkt_err code 2, err_count=1, pkt_valid stays 0. A5 00 -> code 1. A5 11 -> code 1 (len 17).
//  A5 02 11 then idle for 17360 cycles -> pkt_err code 3 exactly TO_CYC cycles after the 0x11 strobe.
//  rx_error during payload -> code 0. rx_ready+rx_error in the same cycle -> code 0, byte not written.
//  Valid frame held (pkt_ready=0), then send 0x77 -> code 4, rd data unchanged.
//  Assert rst mid-payload -> IDLE, err_count=0, then a fresh good frame is received.
//  Force 300 errors -> err_count=255.

Source files
------------

// File: rtl/uart_rx_frame_pkg.sv
// Shared definitions for the UART frame receiver: FSM states, error codes
// and small byte-level helper functions.
package uart_rx_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CSUM    = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

  localparam logic [2:0] ERR_UART    = 3'd0;
  localparam logic [2:0] ERR_LEN     = 3'd1;
  localparam logic [2:0] ERR_CSUM    = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_OVERRUN = 3'd4;

  // A length byte is acceptable when it is in 1..max_len.
  function automatic logic len_ok(input logic [7:0] b, input int max_len);
    return (b != 8'd0) && (int'({24'd0, b}) <= max_len);
  endfunction

  // Running frame checksum: plain XOR of LEN and every payload byte.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/uart_rx_frame_buf.sv
// Payload buffer: DEPTH x 8 simple dual-port RAM, synchronous write,
// registered read. The read register is cleared by reset; the array is not.
module uart_rx_frame_buf
  import uart_rx_frame_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rd_data;

  // Write port: one byte per enabled cycle, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port: registered data, one-cycle latency, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= 8'd0;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/uart_rx_frame.sv
// Frame parser behind uart_rx: hunts SYNC, collects [LEN][PAYLOAD][CSUM],
// holds the checked payload for a ready/valid consumer and reports errors.
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int         CLK_HZ       = 100_000_000,
  parameter int         BAUD         = 115200,
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_ready,
  input  logic                         rx_error,
  input  logic [7:0]                   rx_val,
  output logic                         pkt_valid,
  input  logic                         pkt_ready,
  output logic [$clog2(MAX_LEN+1)-1:0] pkt_len,
  input  logic [$clog2(MAX_LEN)-1:0]   rd_addr,
  output logic [7:0]                   rd_data,
  output logic                         pkt_err,
  output logic [2:0]                   err_code,
  output logic [7:0]                   err_count
);

  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int AW      = $clog2(MAX_LEN);
  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int TO_CYC  = BIT_CYC * TIMEOUT_BITS;
  localparam int TO_W    = $clog2(TO_CYC + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TO_CYC - 1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_e            r_state;
  logic [AW-1:0]     r_idx;
  logic [7:0]        r_csum;
  logic [LEN_W-1:0]  r_len;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_pkt_valid;
  logic              r_pkt_err;
  logic [2:0]        r_err_code;
  logic [7:0]        r_err_count;

  state_e            w_state_nxt;
  logic [AW-1:0]     w_idx_nxt;
  logic [7:0]        w_csum_nxt;
  logic [LEN_W-1:0]  w_len_nxt;
  logic [TO_W-1:0]   w_to_nxt;
  logic              w_err_set;
  logic [2:0]        w_err_code_nxt;
  logic [7:0]        w_err_count_nxt;
  logic              w_wr_en;
  logic              w_nxt_active;

  // Next-state and datapath updates; error priority is rx_error, then byte, then timeout.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_csum_nxt     = r_csum;
    w_len_nxt      = r_len;
    w_err_set      = 1'b0;
    w_err_code_nxt = r_err_code;
    w_wr_en        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (rx_ready && !rx_error && (rx_val == SYNC_BYTE)) begin
          w_state_nxt = ST_LEN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_LEN, ST_PAYLOAD, ST_CSUM: begin
        if (rx_error) begin
          // A line error kills the frame; a byte strobed alongside it is dropped.
          w_err_set      = 1'b1;
          w_err_code_nxt = ERR_UART;
          w_state_nxt    = ST_IDLE;
        end else if (rx_ready) begin
          case (r_state)
            ST_LEN: begin
              if (len_ok(rx_val, MAX_LEN)) begin
                w_len_nxt   = rx_val[LEN_W-1:0];
                w_csum_nxt  = rx_val;
                w_idx_nxt   = '0;
                w_state_nxt = ST_PAYLOAD;
              end else begin
                w_err_set      = 1'b1;
                w_err_code_nxt = ERR_LEN;
                w_state_nxt    = ST_IDLE;
              end
            end
            ST_PAYLOAD: begin
              w_wr_en    = 1'b1;
              w_csum_nxt = csum_step(r_csum, rx_val);
              w_idx_nxt  = r_idx + AW'(1);
              if (LEN_W'(r_idx) == (r_len - LEN_ONE)) begin
                w_state_nxt = ST_CSUM;
              end else begin
                w_state_nxt = ST_PAYLOAD;
              end
            end
            default: begin
              if (rx_val == r_csum) begin
                w_state_nxt = ST_HOLD;
              end else begin
                w_err_set      = 1'b1;
                w_err_code_nxt = ERR_CSUM;
                w_state_nxt    = ST_IDLE;
              end
            end
          endcase
        end else if (r_to_cnt == TO_LAST) begin
          // The counter reaches TO_CYC on this edge: give up on the frame.
          w_err_set      = 1'b1;
          w_err_code_nxt = ERR_TIMEOUT;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end

      ST_HOLD: begin
        // Any byte arriving while the buffer is owned by the consumer is lost.
        if (rx_ready) begin
          w_err_set      = 1'b1;
          w_err_code_nxt = ERR_OVERRUN;
        end else begin
          w_err_set = 1'b0;
        end
        if (pkt_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Inter-byte timer and saturating error counter next values.
  always_comb begin
    w_nxt_active = (w_state_nxt == ST_LEN) || (w_state_nxt == ST_PAYLOAD) ||
                   (w_state_nxt == ST_CSUM);
    if (rx_ready || !w_nxt_active) begin
      w_to_nxt = '0;
    end else begin
      w_to_nxt = r_to_cnt + TO_W'(1);
    end
    if (w_err_set && (r_err_count != 8'hFF)) begin
      w_err_count_nxt = r_err_count + 8'd1;
    end else begin
      w_err_count_nxt = r_err_count;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_csum      <= 8'd0;
      r_len       <= '0;
      r_to_cnt    <= '0;
      r_pkt_valid <= 1'b0;
      r_pkt_err   <= 1'b0;
      r_err_code  <= 3'd0;
      r_err_count <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_csum      <= w_csum_nxt;
      r_len       <= w_len_nxt;
      r_to_cnt    <= w_to_nxt;
      r_pkt_valid <= (w_state_nxt == ST_HOLD);
      r_pkt_err   <= w_err_set;
      r_err_code  <= w_err_code_nxt;
      r_err_count <= w_err_count_nxt;
    end
  end

  uart_rx_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_idx),
    .i_wr_data (rx_val),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data)
  );

  assign pkt_valid = r_pkt_valid;
  assign pkt_len   = r_len;
  assign pkt_err   = r_pkt_err;
  assign err_code  = r_err_code;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame using direct rx_ready/rx_error strobes.
module tb_uart_rx_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_ready = 1'b0;
  logic       rx_error = 1'b0;
  logic [7:0] rx_val = 8'd0;
  logic       pkt_valid;
  logic       pkt_ready = 1'b0;
  logic [4:0] pkt_len;
  logic [3:0] rd_addr = 4'd0;
  logic [7:0] rd_data;
  logic       pkt_err;
  logic [2:0] err_code;
  logic [7:0] err_count;

  int total = 0;
  int bad   = 0;

  uart_rx_frame dut (
    .clk       (clk),
    .rst       (rst),
    .rx_ready  (rx_ready),
    .rx_error  (rx_error),
    .rx_val    (rx_val),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_len   (pkt_len),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .pkt_err   (pkt_err),
    .err_code  (err_code),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_val   = b;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic send_err();
    rx_error = 1'b1;
    @(posedge clk);
    #1;
    rx_error = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
    rd_addr = a;
    @(posedge clk);
    #1;
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic accept();
    pkt_ready = 1'b1;
    @(posedge clk);
    #1;
    pkt_ready = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", 32'(pkt_valid), 32'd0);
    chk("rst_err",   32'(pkt_err),   32'd0);
    chk("rst_len",   32'(pkt_len),   32'd0);
    chk("rst_code",  32'(err_code),  32'd0);
    chk("rst_count", 32'(err_count), 32'd0);
    chk("rst_rd",    32'(rd_data),   32'd0);

    // Basic frame, csum 03^11^22^33 = 03
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
    chk("f1_valid", 32'(pkt_valid), 32'd1);
    chk("f1_len",   32'(pkt_len),   32'd3);
    chk("f1_noerr", 32'(pkt_err),   32'd0);
    rd_chk("f1_rd0", 4'd0, 8'h11);
    rd_chk("f1_rd1", 4'd1, 8'h22);
    rd_chk("f1_rd2", 4'd2, 8'h33);
    accept();
    chk("f1_drop", 32'(pkt_valid), 32'd0);

    // Leading junk ignored, csum 02^AA^55 = FD
    send_byte(8'h95); send_byte(8'h95);
    chk("junk_err",   32'(pkt_err),   32'd0);
    chk("junk_count", 32'(err_count), 32'd0);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA);
    send_byte(8'h55); send_byte(8'hFD);
    chk("f2_valid", 32'(pkt_valid), 32'd1);
    chk("f2_len",   32'(pkt_len),   32'd2);
    rd_chk("f2_rd0", 4'd0, 8'hAA);
    rd_chk("f2_rd1", 4'd1, 8'h55);
    accept();

    // Bad checksum
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h04);
    chk("csum_err",   32'(pkt_err),   32'd1);
    chk("csum_code",  32'(err_code),  32'd2);
    chk("csum_count", 32'(err_count), 32'd1);
    chk("csum_valid", 32'(pkt_valid), 32'd0);
    @(posedge clk); #1;
    chk("csum_pulse", 32'(pkt_err), 32'd0);

    // Length 0 and 17 rejected
    send_byte(8'hA5); send_byte(8'h00);
    chk("len0_code",  32'(err_code),  32'd1);
    chk("len0_count", 32'(err_count), 32'd2);
    send_byte(8'hA5); send_byte(8'h11);
    chk("len17_err",   32'(pkt_err),   32'd1);
    chk("len17_code",  32'(err_code),  32'd1);
    chk("len17_count", 32'(err_count), 32'd3);

    // Maximum length 16, payload 00..0F, csum 10^00^..^0F = 10
    send_byte(8'hA5); send_byte(8'h10);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    send_byte(8'h10);
    chk("max_valid", 32'(pkt_valid), 32'd1);
    chk("max_len",   32'(pkt_len),   32'd16);
    rd_chk("max_rd15", 4'd15, 8'h0F);
    accept();

    // Timeout: pkt_err rises exactly 17360 edges after the 0x11 strobe edge
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    repeat (17359) @(posedge clk);
    #1;
    chk("to_early", 32'(pkt_err), 32'd0);
    @(posedge clk); #1;
    chk("to_err",   32'(pkt_err),   32'd1);
    chk("to_code",  32'(err_code),  32'd3);
    chk("to_count", 32'(err_count), 32'd4);

    // Line error during payload
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    send_err();
    chk("uart_err",   32'(pkt_err),   32'd1);
    chk("uart_code",  32'(err_code),  32'd0);
    chk("uart_count", 32'(err_count), 32'd5);

    // Byte and line error together: error wins, byte not stored (buf[1] still 01)
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    rx_val = 8'hEE; rx_ready = 1'b1; rx_error = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0; rx_error = 1'b0;
    chk("both_code",  32'(err_code),  32'd0);
    chk("both_count", 32'(err_count), 32'd6);
    rd_chk("both_rd1", 4'd1, 8'h01);

    // Overrun while holding, csum 01^42 = 43
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h42); send_byte(8'h43);
    chk("ovr_valid0", 32'(pkt_valid), 32'd1);
    send_byte(8'h77);
    chk("ovr_err",   32'(pkt_err),   32'd1);
    chk("ovr_code",  32'(err_code),  32'd4);
    chk("ovr_count", 32'(err_count), 32'd7);
    chk("ovr_valid", 32'(pkt_valid), 32'd1);
    chk("ovr_len",   32'(pkt_len),   32'd1);
    rd_chk("ovr_rd0", 4'd0, 8'h42);
    rd_chk("ovr_rd1", 4'd1, 8'h01);
    // Overrun on the handshake cycle itself
    rx_val = 8'h78; rx_ready = 1'b1; pkt_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0; pkt_ready = 1'b0;
    chk("ovr_hs_err",   32'(pkt_err),   32'd1);
    chk("ovr_hs_count", 32'(err_count), 32'd8);
    chk("ovr_hs_valid", 32'(pkt_valid), 32'd0);
    rd_chk("ovr_hs_rd1", 4'd1, 8'h01);

    // Reset mid-payload, then a fresh good frame
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_count", 32'(err_count), 32'd0);
    chk("mid_valid", 32'(pkt_valid), 32'd0);
    chk("mid_code",  32'(err_code),  32'd0);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA);
    send_byte(8'h55); send_byte(8'hFD);
    chk("mid_f_valid", 32'(pkt_valid), 32'd1);
    chk("mid_f_len",   32'(pkt_len),   32'd2);
    chk("mid_f_count", 32'(err_count), 32'd0);
    accept();

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      send_byte(8'hA5); send_byte(8'h00);
      if (i == 9) chk("sat_10", 32'(err_count), 32'd10);
    end
    chk("sat_count", 32'(err_count), 32'd255);
    chk("sat_code",  32'(err_code),  32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
